// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported unified memory between the IF and MEM pipeline stages.
// MEM has priority; IF gets a forced grant after STARVE_MAX consecutive contended losses.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // Instruction fetch side
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              flush,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  // Load/store side
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [3:0]        mem_be,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_rdata,
  // Pipeline stalls
  output logic              stall_if,
  output logic              stall_mem,
  // Memory port
  output logic              ram_req,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ready
);

  localparam int unsigned CntW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] StarveLim = CntW'(STARVE_MAX);

  typedef enum logic [1:0] {
    StIdle,
    StBusyIf,
    StBusyMem,
    StDrain
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   starve_q, starve_d;
  logic              ram_req_q, ram_req_d;
  logic              ram_we_q, ram_we_d;
  logic [3:0]        ram_be_q, ram_be_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              mem_done_q, mem_done_d;

  logic mem_elig, if_elig, grant_if, grant_mem;

  // A requester whose done pulse is high is advancing this edge, so it is not re-granted.
  assign mem_elig  = mem_req & ~mem_done_q;
  assign if_elig   = if_req & ~if_valid_q & ~flush;
  assign grant_if  = if_elig & (~mem_elig | (starve_q == StarveLim));
  assign grant_mem = mem_elig & ~grant_if;

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    ram_req_d   = ram_req_q;
    ram_we_d    = ram_we_q;
    ram_be_d    = ram_be_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_valid_d  = 1'b0;
    mem_done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (grant_mem) begin
          state_d     = StBusyMem;
          ram_req_d   = 1'b1;
          ram_we_d    = mem_we;
          ram_be_d    = mem_be;
          ram_addr_d  = mem_addr;
          ram_wdata_d = mem_wdata;
          if (if_elig && (starve_q != StarveLim)) begin
            starve_d = starve_q + CntW'(1);
          end
        end else if (grant_if) begin
          state_d    = StBusyIf;
          ram_req_d  = 1'b1;
          ram_we_d   = 1'b0;
          ram_be_d   = 4'hF;
          ram_addr_d = if_addr;
          starve_d   = '0;
        end
      end

      StBusyMem: begin
        if (ram_ready) begin
          state_d    = StIdle;
          ram_req_d  = 1'b0;
          ram_we_d   = 1'b0;
          mem_done_d = 1'b1;
          if (!ram_we_q) begin
            mem_rdata_d = ram_rdata;
          end
        end
      end

      StBusyIf: begin
        if (ram_ready) begin
          state_d   = StIdle;
          ram_req_d = 1'b0;
          if (!flush) begin
            if_rdata_d = ram_rdata;
            if_valid_d = 1'b1;
          end
        end else if (flush) begin
          state_d = StDrain;
        end
      end

      // Squashed fetch still owns the memory until it completes; its data is dropped.
      StDrain: begin
        if (ram_ready) begin
          state_d   = StIdle;
          ram_req_d = 1'b0;
        end
      end

      default: begin
        state_d   = StIdle;
        ram_req_d = 1'b0;
        ram_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      starve_q    <= '0;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_be_q    <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_valid_q  <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      ram_req_q   <= ram_req_d;
      ram_we_q    <= ram_we_d;
      ram_be_q    <= ram_be_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_valid_q  <= if_valid_d;
      mem_done_q  <= mem_done_d;
    end
  end

  assign ram_req   = ram_req_q;
  assign ram_we    = ram_we_q;
  assign ram_be    = ram_be_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign if_valid  = if_valid_q;
  assign if_rdata  = if_rdata_q;
  assign mem_done  = mem_done_q;
  assign mem_rdata = mem_rdata_q;

  assign stall_mem = mem_req & ~mem_done_q;
  assign stall_if  = (if_req & ~if_valid_q) | stall_mem | (state_q == StDrain);

`ifndef SYNTHESIS
  a_one_pulse: assert property (@(posedge clk) disable iff (!rst_n) !(if_valid_q && mem_done_q));
  a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (ram_req_q && !ram_ready) |=> (ram_req_q && $stable(ram_addr_q) && $stable(ram_we_q)));
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected done pulses queued at issue, checked by a monitor.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, flush, if_valid;
  logic [31:0] if_addr, if_rdata;
  logic        mem_req, mem_we, mem_done;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall_if, stall_mem;
  logic        ram_req, ram_we, ram_ready;
  logic [3:0]  ram_be;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  int checks = 0;
  int errors = 0;
  int delay = 0;
  int rcnt = 0;
  logic [31:0] exp_mrd = 32'h0;

  typedef struct packed {
    logic        is_mem;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .flush(flush),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .ram_req(ram_req), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ready(ram_ready)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h0050_0093;
      32'h0000_3000: return 32'h1234_5678;
      default:       return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  // Memory responder: asserts ram_ready 'delay' cycles after ram_req is first seen.
  always @(posedge clk) begin
    #1;
    if (ram_req) begin
      if (rcnt >= delay) begin
        ram_ready = 1'b1;
        ram_rdata = mem_word(ram_addr);
        rcnt = 0;
      end else begin
        ram_ready = 1'b0;
        rcnt = rcnt + 1;
      end
    end else begin
      ram_ready = 1'b0;
      rcnt = 0;
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] got;
    if (rst_n) begin
      if (if_valid && mem_done) begin
        checks++;
        errors++;
        $display("FAIL both_pulses: if_valid and mem_done high together");
      end else if (if_valid || mem_done) begin
        checks++;
        got = mem_done ? mem_rdata : if_rdata;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL spurious_pulse: is_mem=%0b data=%h, none expected", mem_done, got);
        end else begin
          e = sb.pop_front();
          if (e.is_mem != mem_done || e.data != got) begin
            errors++;
            $display("FAIL pulse: got is_mem=%0b data=%h, want is_mem=%0b data=%h",
                     mem_done, got, e.is_mem, e.data);
          end
        end
      end
    end
  end

  task automatic push(input logic is_mem, input logic [31:0] data);
    exp_t e;
    e.is_mem = is_mem;
    e.data   = data;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input bit is_mem);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      cyc();
      seen = is_mem ? mem_done : if_valid;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL timeout: got no done pulse want is_mem=%0b pulse", is_mem);
    end
  endtask

  task automatic issue_both(input logic mwe, input logic [31:0] maddr, input logic [31:0] mwdata,
                            input logic [31:0] iaddr, input bit mem_first);
    logic [31:0] mexp;
    mexp = mwe ? exp_mrd : mem_word(maddr);
    if (!mwe) exp_mrd = mexp;
    mem_req = 1'b1; mem_we = mwe; mem_be = 4'hF; mem_addr = maddr; mem_wdata = mwdata;
    if_req = 1'b1; if_addr = iaddr;
    if (mem_first) begin
      push(1'b1, mexp); push(1'b0, mem_word(iaddr));
    end else begin
      push(1'b0, mem_word(iaddr)); push(1'b1, mexp);
    end
    cyc();
    chk("first_addr", ram_addr, mem_first ? maddr : iaddr);
    chk("first_we", {31'b0, ram_we}, {31'b0, mem_first ? mwe : 1'b0});
    chk("first_be", {28'b0, ram_be}, 32'hF);
    if (mem_first && mwe) chk("store_wdata", ram_wdata, mwdata);
    wait_done(mem_first);
    if (mem_first) mem_req = 1'b0;
    else if_req = 1'b0;
    cyc();
    chk("second_addr", ram_addr, mem_first ? iaddr : maddr);
    wait_done(!mem_first);
    mem_req = 1'b0; if_req = 1'b0;
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; flush = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_be = '0; mem_addr = '0; mem_wdata = '0;
    ram_ready = 1'b0; ram_rdata = '0;
    cyc(); cyc();
    chk("rst_ram_req", {31'b0, ram_req}, 32'h0);
    chk("rst_ram_addr", ram_addr, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    chk("rst_pulses", {30'b0, if_valid, mem_done}, 32'h0);
    rst_n = 1'b1;
    cyc();

    // Single fetch at minimum latency
    if_req = 1'b1; if_addr = 32'h100; push(1'b0, 32'h0050_0093);
    #1;
    chk("f1_stall_if", {31'b0, stall_if}, 32'h1);
    chk("f1_stall_mem", {31'b0, stall_mem}, 32'h0);
    cyc();
    chk("f1_ram_req", {31'b0, ram_req}, 32'h1);
    chk("f1_ram_addr", ram_addr, 32'h100);
    chk("f1_ram_we", {31'b0, ram_we}, 32'h0);
    chk("f1_stall_if_busy", {31'b0, stall_if}, 32'h1);
    cyc();
    chk("f1_if_valid", {31'b0, if_valid}, 32'h1);
    chk("f1_if_rdata", if_rdata, 32'h0050_0093);
    chk("f1_stall_if_done", {31'b0, stall_if}, 32'h0);
    if_req = 1'b0;
    cyc();
    chk("f1_pulse_len", {31'b0, if_valid}, 32'h0);
    chk("f1_ram_req_drop", {31'b0, ram_req}, 32'h0);

    // Contention: store wins, then fetch
    issue_both(1'b1, 32'h2000, 32'hDEAD_BEEF, 32'h104, 1'b1);

    // Starvation guard: four contended MEM wins, then IF is forced ahead
    for (int g = 0; g < 5; g++) begin
      mem_req = 1'b1; mem_we = 1'b0; mem_be = 4'hF; mem_addr = 32'h4000 + 32'(4 * g);
      if_req = 1'b1; if_addr = 32'h200;
      if (g < 4) begin
        push(1'b1, mem_word(mem_addr)); exp_mrd = mem_word(mem_addr);
        cyc();
        chk("starve_mem_win", ram_addr, 32'h4000 + 32'(4 * g));
        wait_done(1'b1);
        if_req = 1'b0;
        cyc();
      end else begin
        push(1'b0, mem_word(32'h200));
        push(1'b1, mem_word(32'h4010)); exp_mrd = mem_word(32'h4010);
        cyc();
        chk("starve_if_forced", ram_addr, 32'h200);
        wait_done(1'b0);
        if_req = 1'b0;
        cyc();
        chk("starve_mem_after", ram_addr, 32'h4010);
        wait_done(1'b1);
        mem_req = 1'b0;
        cyc();
      end
    end
    // Counter cleared: MEM wins the next contention again
    issue_both(1'b0, 32'h4020, 32'h0, 32'h204, 1'b1);

    // Flush during a slow fetch: drain, no pulse, refetch at new address
    delay = 3;
    if_req = 1'b1; if_addr = 32'h300;
    cyc();
    chk("dr_ram_addr", ram_addr, 32'h300);
    flush = 1'b1; if_addr = 32'h500;
    cyc();
    flush = 1'b0; if_req = 1'b0;
    #1;
    chk("dr_stall_if", {31'b0, stall_if}, 32'h1);
    chk("dr_ram_hold", ram_addr, 32'h300);
    cyc();
    chk("dr_stall_if2", {31'b0, stall_if}, 32'h1);
    cyc();
    chk("dr_req_held", {31'b0, ram_req}, 32'h1);
    cyc();
    chk("dr_req_done", {31'b0, ram_req}, 32'h0);
    chk("dr_stall_free", {31'b0, stall_if}, 32'h0);
    delay = 0;
    if_req = 1'b1; push(1'b0, mem_word(32'h500));
    cyc();
    chk("dr_new_addr", ram_addr, 32'h500);
    wait_done(1'b0);
    if_req = 1'b0;
    cyc();

    // Flush on the ready cycle discards the word
    if_req = 1'b1; if_addr = 32'h600;
    cyc();
    flush = 1'b1;
    cyc();
    chk("fr_no_valid", {31'b0, if_valid}, 32'h0);
    flush = 1'b0; if_addr = 32'h700; push(1'b0, mem_word(32'h700));
    cyc();
    chk("fr_new_addr", ram_addr, 32'h700);
    wait_done(1'b0);
    if_req = 1'b0;
    cyc();

    // Slow load: address stable, stalls held
    delay = 5;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h3000; push(1'b1, 32'h1234_5678);
    exp_mrd = 32'h1234_5678;
    cyc();
    for (int k = 0; k < 5; k++) begin
      chk("ld_addr_stable", ram_addr, 32'h3000);
      chk("ld_stalls", {30'b0, stall_mem, stall_if}, 32'h3);
      cyc();
    end
    for (int k = 0; k < 30 && !mem_done; k++) cyc();
    chk("ld_done", {31'b0, mem_done}, 32'h1);
    chk("ld_rdata", mem_rdata, 32'h1234_5678);
    chk("ld_stall_release", {31'b0, stall_mem}, 32'h0);
    mem_req = 1'b0;
    cyc();

    // Store leaves mem_rdata unchanged
    delay = 0;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h3004; mem_wdata = 32'hCAFE_F00D;
    push(1'b1, exp_mrd);
    cyc();
    chk("st_we", {31'b0, ram_we}, 32'h1);
    wait_done(1'b1);
    mem_req = 1'b0;
    cyc();

    // Reset while BUSY_MEM abandons the access
    delay = 5;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h2400;
    cyc();
    chk("rm_busy", {31'b0, ram_req}, 32'h1);
    rst_n = 1'b0; mem_req = 1'b0;
    cyc();
    chk("rm_ram_req", {31'b0, ram_req}, 32'h0);
    chk("rm_ram_addr", ram_addr, 32'h0);
    chk("rm_mem_rdata", mem_rdata, 32'h0);
    chk("rm_pulses", {30'b0, if_valid, mem_done}, 32'h0);
    rst_n = 1'b1; delay = 0;
    cyc();
    chk("rm_no_done", {31'b0, mem_done}, 32'h0);
    if_req = 1'b1; if_addr = 32'h100; push(1'b0, 32'h0050_0093);
    cyc();
    chk("rm_refetch", ram_addr, 32'h100);
    wait_done(1'b0);
    if_req = 1'b0;
    cyc(); cyc();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d unserved expectations want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-ported unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline. Grants one requester at a time, drives the memory handshake, and returns read data with a one-cycle done pulse. Exports per-stage stall signals that the pipeline control ORs with the load-use stall. MEM has priority, with an anti-starvation guard for IF and flush-aware discard of squashed fetches.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data word width
STARVE_MAX, 4, consecutive IF losses before IF is forced ahead of MEM once (≥1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
if_req  in  1  IF wants an instruction word
if_addr  in  ADDR_W  fetch address (PC)
flush  in  1  taken branch/jump; squash current fetch
if_valid  out  1  one-cycle pulse, if_rdata valid
if_rdata  out  DATA_W  fetched instruction (registered)
mem_req  in  1  MEM wants access (MemRead|MemWrite)
mem_we  in  1  1 = store, 0 = load
mem_be  in  4  store byte enables
mem_addr  in  ADDR_W  data address
mem_wdata  in  DATA_W  store data
mem_done  out  1  one-cycle pulse, access complete
mem_rdata  out  DATA_W  load data (registered)
stall_if  out  1  hold PC and IF/ID
stall_mem  out  1  hold EX/MEM and all earlier stages
ram_req  out  1  memory request (registered)
ram_we  out  1  write strobe
ram_be  out  4  byte enables
ram_addr  out  ADDR_W  memory address
ram_wdata  out  DATA_W  write data
ram_rdata  in  DATA_W  read data, valid when ram_ready=1
ram_ready  in  1  memory completes the current request this cycle

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; ram_req, ram_we, if_valid, mem_done = 0; ram_be, ram_addr, ram_wdata, if_rdata, mem_rdata = 0; starve_cnt = 0. Reset mid-transaction abandons it with no done pulse; memory must accept a dropped ram_req.
- States: IDLE, BUSY_IF, BUSY_MEM, DRAIN.
- Eligibility in IDLE: mem eligible = mem_req & ~mem_done; if eligible = if_req & ~if_valid & ~flush. A requester whose done pulse is high that cycle is not re-granted, since the pipeline advances at that edge.
- IDLE grant: if both are eligible, MEM wins unless starve_cnt == STARVE_MAX. Otherwise the sole eligible requester wins.
- On a grant: latch addr/we/be/wdata into the ram_* registers, set ram_req=1, and go to BUSY_MEM or BUSY_IF. ram_we=1 only for a MEM store; fetches drive ram_we=0, ram_be=4'hF.
- starve_cnt: +1 when IF is eligible and MEM is granted; cleared to 0 when IF is granted; saturates at STARVE_MAX.
- ram_* outputs hold stable while ram_req=1 until ram_ready is sampled high.
- BUSY_MEM, ram_ready=1: register ram_rdata into mem_rdata (loads only; stores leave mem_rdata unchanged). Next cycle: mem_done=1, ram_req=0, state IDLE.
- BUSY_IF, ram_ready=1, flush=0: register if_rdata, then if_valid=1 next cycle, state IDLE.
- BUSY_IF, ram_ready=1, flush=1: data discarded, no if_valid, state IDLE.
- BUSY_IF, ram_ready=0, flush=1: state DRAIN. ram_req is held until ram_ready, then state IDLE with no pulse. flush is ignored in the other states.
- Minimum latency: request seen in IDLE at cycle 0, ram_req at cycle 1, ram_ready at cycle 1, done pulse at cycle 2. Back-to-back accesses need one IDLE cycle between them.
- stall_mem = mem_req & ~mem_done (combinational).
- stall_if = (if_req & ~if_valid) | stall_mem | (state==DRAIN).
- Done pulses are exactly one cycle long. if_valid and mem_done are never high together.
- No combinational path from ram_ready to ram_req, so back-to-back grants cannot occur.

Test Plan:
- Reset, then if_req=1, if_addr=0x100, ram_ready=1 one cycle after ram_req: ram_addr=0x100, ram_we=0, then if_valid=1 for 1 cycle with if_rdata=ram_rdata (e.g. 0x00500093); stall_if high until that pulse.
- if_req and mem_req (store, addr 0x2000, wdata 0xDEADBEEF, be 4'hF) in the same IDLE cycle: MEM granted first with ram_we=1 and mem_done pulse; IF granted next, if_valid after it.
- MEM requests continuously win over a pending IF for 4 grants (STARVE_MAX=4): the 5th contended grant goes to IF; starve_cnt returns to 0.
- Fetch in flight with ram_ready held low 3 cycles, flush pulsed in cycle 1: DRAIN until ram_ready; no if_valid for the old address; the next fetch uses the new if_addr.
- Load at 0x3000, ram_ready delayed 5 cycles: ram_addr stable for all 5 cycles; stall_mem and stall_if held high; mem_rdata = ram_rdata captured on the ready cycle; mem_done for 1 cycle.
- rst_n=0 while in BUSY_MEM: next cycle ram_req=0, state IDLE, no mem_done, all outputs at reset values.
